// File: rtl/demux12_fifo.sv
// Steers one valid-qualified input stream into one of two independent FIFO lanes.
// Each lane drains under its own pop; a push to a full lane is discarded and flagged on drop.
module demux12_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             select,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             pop0,
    input  logic             pop1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             full0,
    output logic             full1,
    output logic             empty0,
    output logic             empty1,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem       [2][DEPTH];
    logic [AW-1:0]    r_wptr      [2];
    logic [AW-1:0]    r_rptr      [2];
    logic [AW:0]      r_count     [2];
    logic [WIDTH-1:0] r_out       [2];
    logic [1:0]       r_out_valid;
    logic             r_drop;

    logic [1:0] w_pop_req;
    logic [1:0] w_full;
    logic [1:0] w_empty;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic       w_drop;

    // Flags come from the registered count, so a same-cycle pop never frees room for a push
    // and a same-cycle push never makes an empty lane poppable.
    always_comb begin
        w_pop_req = {pop1, pop0};
        w_full    = '0;
        w_empty   = '0;
        w_push    = '0;
        w_pop     = '0;
        for (int l = 0; l < 2; l++) begin
            w_full[l]  = (r_count[l] == CNT_FULL);
            w_empty[l] = (r_count[l] == '0);
            w_push[l]  = in_valid && (select == 1'(l)) && !w_full[l];
            w_pop[l]   = w_pop_req[l] && !w_empty[l];
        end
        w_drop = in_valid && (select ? w_full[1] : w_full[0]);
    end

    // Storage array carries no reset; its contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                if (w_push[l]) begin
                    r_mem[l][r_wptr[l]] <= in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                r_wptr[l]  <= '0;
                r_rptr[l]  <= '0;
                r_count[l] <= '0;
                r_out[l]   <= '0;
            end
            r_out_valid <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop      <= w_drop;
            r_out_valid <= w_pop;
            for (int l = 0; l < 2; l++) begin
                if (w_push[l]) begin
                    r_wptr[l] <= r_wptr[l] + PTR_ONE;
                end
                if (w_pop[l]) begin
                    r_out[l]  <= r_mem[l][r_rptr[l]];
                    r_rptr[l] <= r_rptr[l] + PTR_ONE;
                end
                case ({w_push[l], w_pop[l]})
                    2'b10:   r_count[l] <= r_count[l] + CNT_ONE;
                    2'b01:   r_count[l] <= r_count[l] - CNT_ONE;
                    default: r_count[l] <= r_count[l];
                endcase
            end
        end
    end

    assign out0       = r_out[0];
    assign out1       = r_out[1];
    assign out0_valid = r_out_valid[0];
    assign out1_valid = r_out_valid[1];
    assign full0      = w_full[0];
    assign full1      = w_full[1];
    assign empty0     = w_empty[0];
    assign empty1     = w_empty[1];
    assign drop       = r_drop;

endmodule

// File: tb/tb_demux12_fifo.sv
// Directed-vector bench for demux12_fifo (WIDTH=2, DEPTH=4) with hand-computed expectations.
module tb_demux12_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       select;
    logic [1:0] in;
    logic       in_valid;
    logic       pop0, pop1;
    logic [1:0] out0, out1;
    logic       out0_valid, out1_valid;
    logic       full0, full1, empty0, empty1;
    logic       drop;

    int n_vec = 0;
    int n_err = 0;

    demux12_fifo #(.WIDTH(2), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .select     (select),
        .in         (in),
        .in_valid   (in_valid),
        .pop0       (pop0),
        .pop1       (pop1),
        .out0       (out0),
        .out1       (out1),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .full0      (full0),
        .full1      (full1),
        .empty0     (empty0),
        .empty1     (empty1),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e0, input logic f0,
                             input logic e1, input logic f1);
        chk_b({tag, ".empty0"}, empty0, e0);
        chk_b({tag, ".full0"},  full0,  f0);
        chk_b({tag, ".empty1"}, empty1, e1);
        chk_b({tag, ".full1"},  full1,  f1);
    endtask

    task automatic push(input logic sel, input logic [1:0] d);
        in_valid = 1'b1;
        select   = sel;
        in       = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        select   = 1'b0;
        in       = 2'b11;
        in_valid = 1'b1;
        pop0     = 1'b1;
        pop1     = 1'b1;
        @(negedge clk);

        // Reset held two cycles with live-looking inputs
        for (int i = 0; i < 2; i++) begin
            step();
            chk_d("rst.out0", out0, 2'b00);
            chk_d("rst.out1", out1, 2'b00);
            chk_b("rst.v0", out0_valid, 1'b0);
            chk_b("rst.v1", out1_valid, 1'b0);
            chk_b("rst.drop", drop, 1'b0);
            chk_flags("rst", 1'b1, 1'b0, 1'b1, 1'b0);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        pop0     = 1'b0;
        pop1     = 1'b0;
        step();
        chk_flags("idle", 1'b1, 1'b0, 1'b1, 1'b0);

        // Basic routing
        push(1'b0, 2'b01);
        chk_flags("route.p0", 1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b1, 2'b10);
        chk_flags("route.p1", 1'b0, 1'b0, 1'b0, 1'b0);
        pop0 = 1'b1;
        pop1 = 1'b1;
        step();
        pop0 = 1'b0;
        pop1 = 1'b0;
        chk_d("route.out0", out0, 2'b01);
        chk_d("route.out1", out1, 2'b10);
        chk_b("route.v0", out0_valid, 1'b1);
        chk_b("route.v1", out1_valid, 1'b1);
        chk_flags("route.drained", 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_b("route.v0_once", out0_valid, 1'b0);
        chk_b("route.v1_once", out1_valid, 1'b0);
        chk_d("route.out0_hold", out0, 2'b01);
        chk_d("route.out1_hold", out1, 2'b10);

        // Fill lane 0 and overflow
        for (int i = 0; i < 4; i++) push(1'b0, 2'(i));
        chk_flags("fill", 1'b0, 1'b1, 1'b1, 1'b0);
        chk_b("fill.nodrop", drop, 1'b0);
        push(1'b0, 2'b11);
        chk_b("ovf.drop", drop, 1'b1);
        chk_flags("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_b("ovf.drop_pulse", drop, 1'b0);
        pop0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_d("drain.out0", out0, 2'(i));
            chk_b("drain.v0", out0_valid, 1'b1);
        end
        pop0 = 1'b0;
        chk_flags("drain.empty", 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_b("drain.v0_off", out0_valid, 1'b0);

        // Lane 1 pointer wrap with interleaved push/pop
        for (int i = 0; i < 10; i++) begin
            push(1'b1, 2'(i % 4));
            chk_b("wrap.ne1", empty1, 1'b0);
            chk_b("wrap.nf1", full1, 1'b0);
            pop1 = 1'b1;
            step();
            pop1 = 1'b0;
            chk_d("wrap.out1", out1, 2'(i % 4));
            chk_b("wrap.v1", out1_valid, 1'b1);
            chk_b("wrap.e1", empty1, 1'b1);
        end

        // Lane 0 full: same-cycle push and pop
        push(1'b0, 2'b01);
        push(1'b0, 2'b10);
        push(1'b0, 2'b11);
        push(1'b0, 2'b00);
        chk_b("fp.full0", full0, 1'b1);
        in_valid = 1'b1;
        select   = 1'b0;
        in       = 2'b11;
        pop0     = 1'b1;
        step();
        in_valid = 1'b0;
        chk_d("fp.out0", out0, 2'b01);
        chk_b("fp.v0", out0_valid, 1'b1);
        chk_b("fp.drop", drop, 1'b1);
        chk_b("fp.nfull0", full0, 1'b0);
        step();
        chk_d("fp.out0_b", out0, 2'b10);
        chk_b("fp.drop_pulse", drop, 1'b0);
        step();
        chk_d("fp.out0_c", out0, 2'b11);
        step();
        chk_d("fp.out0_d", out0, 2'b00);
        chk_b("fp.cnt3_empty", empty0, 1'b1);
        pop0 = 1'b0;
        step();
        chk_b("fp.v0_off", out0_valid, 1'b0);

        // Lane 1 empty: same-cycle push and pop
        in_valid = 1'b1;
        select   = 1'b1;
        in       = 2'b10;
        pop1     = 1'b1;
        step();
        in_valid = 1'b0;
        chk_b("ep.v1", out1_valid, 1'b0);
        chk_b("ep.ne1", empty1, 1'b0);
        step();
        pop1 = 1'b0;
        chk_d("ep.out1", out1, 2'b10);
        chk_b("ep.v1b", out1_valid, 1'b1);
        chk_b("ep.e1", empty1, 1'b1);

        // Reset mid-stream with three words buffered in lane 0
        push(1'b0, 2'b01);
        push(1'b0, 2'b10);
        push(1'b0, 2'b11);
        chk_b("mr.ne0", empty0, 1'b0);
        reset = 1'b0;
        pop0  = 1'b1;
        step();
        reset = 1'b1;
        chk_b("mr.e0", empty0, 1'b1);
        chk_b("mr.v0", out0_valid, 1'b0);
        chk_d("mr.out0", out0, 2'b00);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_b("mr.v0_after", out0_valid, 1'b0);
            chk_b("mr.e0_after", empty0, 1'b1);
        end
        pop0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux12_fifo.md
# demux12_fifo

Two-way valid-qualified demultiplexer with per-output buffering: one input stream is steered by `select` into one of two output FIFOs, and each FIFO drains independently under its consumer's `pop`. It is the splitting end of the 2:1 valid-muxed links in the multiplexer-with-valid datapath. It takes one merged stream, sends each word to one of two lanes, and absorbs rate differences between the producer and the two consumers.

## Interface
Parameters:
- `WIDTH`, 2: data word width in bits.
- `DEPTH`, 4: entries per FIFO. Must be a power of two and at least 2.

Ports:
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: reset, synchronous, active-low.
- `select`, input, 1: destination of the current input word. 0 selects lane 0, 1 selects lane 1.
- `in`, input, WIDTH: input data word.
- `in_valid`, input, 1: marks `in` as valid this cycle.
- `pop0`, `pop1`, input, 1 each: consumer read request for lane 0 or lane 1.
- `out0`, `out1`, output, WIDTH each: registered read data for each lane.
- `out0_valid`, `out1_valid`, output, 1 each: `outN` holds a freshly popped word this cycle.
- `full0`, `full1`, output, 1 each: lane FIFO holds DEPTH entries.
- `empty0`, `empty1`, output, 1 each: lane FIFO holds 0 entries.
- `drop`, output, 1: one-cycle pulse. The previous cycle's valid word was discarded because its target lane was full.

## Operation
- Storage per lane: DEPTH x WIDTH array, write pointer, read pointer, and an occupancy count of log2(DEPTH)+1 bits.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push:
  - Condition: `in_valid`=1 and the lane chosen by `select` is not full, with fullness sampled at the start of the cycle.
  - Effect: `in` is written at that lane's write pointer, then the write pointer increments.
  - The non-selected lane is unaffected.
- Drop:
  - Condition: `in_valid`=1 and the selected lane is full.
  - Effect: the word is discarded and `drop`=1 on the next cycle. There is no backpressure port; the producer must monitor `fullN`.
- Pop:
  - Condition: `popN`=1 and lane N is not empty, with emptiness sampled at the start of the cycle.
  - Effect: the head entry is registered into `outN`, `outN_valid` is 1 next cycle, and the read pointer increments.
  - If `popN`=0 or the lane is empty, `outN_valid` is 0 next cycle and `outN` holds its last value.
- Simultaneous push and pop on the same lane:
  - Lane neither full nor empty: both occur and the count is unchanged.
  - Lane full: the pop occurs and the push is dropped. The full flag is not bypassed.
  - Lane empty: the push occurs and the pop is ignored. There is no write-through; the word is readable from the next cycle.
- `select` and `in` are ignored when `in_valid`=0.
- Flags are combinational decodes of the registered count: `fullN` = (count==DEPTH), `emptyN` = (count==0).

## Timing
- Reset (`reset`=0 at a rising edge):
  - Pointers and counts clear to 0.
  - `out0`, `out1` = 0; `out0_valid`, `out1_valid` = 0; `drop` = 0.
  - `empty0`, `empty1` = 1; `full0`, `full1` = 0.
  - Array contents are don't-care.
- Reset asserted mid-operation discards all buffered words immediately; nothing stored before the reset is ever output afterwards.
- Inputs are ignored during any cycle in which `reset`=0.
- Write-to-readable latency: a word pushed at edge T makes `emptyN`=0 after T. A pop requested in the cycle after T is captured at edge T+1 and appears on `outN` with `outN_valid`=1 after T+1.
- Pop latency is 1 cycle from the `popN` sample to `outN_valid`.
- Throughput: one push per cycle total across both lanes, and one pop per cycle per lane.
- `drop` asserts 1 cycle after the rejected input.
- Word ordering within a lane is strictly FIFO. Ordering between the two lanes is not preserved.

## Test plan
- Reset behaviour: hold `reset`=0 for 2 cycles with `in_valid`=1. Required: all outputs at their reset values, both `emptyN`=1, and `drop`=0 throughout.
- Basic routing:
  - Stimulus: push 2'b01 to lane 0, then 2'b10 to lane 1. Next cycle, pulse `pop0` and `pop1` together.
  - Required: `out0`=2'b01 and `out1`=2'b10, each with valid=1 for exactly one cycle, then both empty flags = 1.
- Fill and overflow:
  - Stimulus: push 0,1,2,3 to lane 0. Required: `full0`=1.
  - Stimulus: push 2'b11 to lane 0. Required: `drop`=1 one cycle later, count stays at 4.
  - Stimulus: pop 4 times. Required: outputs 0,1,2,3 in order, then `empty0`=1.
- Pointer wrap-around:
  - Stimulus: run 10 interleaved push/pop pairs on lane 1 with data 0..9 mod 4.
  - Required: read data sequence equals write sequence, and occupancy never exceeds 1.
- Simultaneous boundary events:
  - Lane 0 full, push+pop in the same cycle: head popped, `drop`=1, count=3.
  - Lane 1 empty, push+pop in the same cycle: `out1_valid`=0, then count=1.
- Reset mid-stream:
  - Stimulus: with 3 words in lane 0, assert reset for 1 cycle, then pop.
  - Required: `out0_valid` stays 0, and `empty0` is 1 from the reset edge onward.
